// File: rtl/base_tag_freelist_pkg.sv
// base_tag_freelist_pkg: shared depth helper and INIT/RUN state encoding for the tag free list.
package base_tag_freelist_pkg;
  localparam logic INIT = 1'b0;
  localparam logic RUN = 1'b1;
  function automatic int tag_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/base_tag_freelist_fifo.sv
// base_tag_fifo: register-array FIFO of tags with head data and occupancy count, no bypass.
module base_tag_fifo
  import base_tag_freelist_pkg::*;
#(
  parameter int a_width = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [a_width-1:0] i_push_data,
  input  logic               i_pop,
  output logic [a_width-1:0] o_head,
  output logic [a_width:0]   o_count
);
  localparam int DEPTH = tag_depth(a_width);
  localparam logic [a_width:0] FULL = {1'b1, {a_width{1'b0}}};
  localparam logic [a_width-1:0] ONE = {{(a_width-1){1'b0}}, 1'b1};
  logic [a_width-1:0] r_mem [DEPTH];
  logic [a_width-1:0] r_head, r_tail;
  logic [a_width:0]   r_count;
  logic               w_push, w_pop;
  assign w_pop   = i_pop & (r_count != '0);
  assign w_push  = i_push & ((r_count != FULL) | w_pop);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + ONE;
      end
      if (w_pop) r_head <= r_head + ONE;
      r_count <= r_count + {{a_width{1'b0}}, w_push} - {{a_width{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/base_tag_freelist.sv
// base_tag_freelist: free-list tag allocator driving a valid-bit array's set/reset ports.
// Define BASE_TAG_FREELIST_CHK_EN to track in-use tags and drop double frees.
module base_tag_freelist
  import base_tag_freelist_pkg::*;
#(
  parameter int a_width = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               o_alloc_v,
  input  logic               i_alloc_r,
  output logic [a_width-1:0] o_alloc_tag,
  input  logic               i_free_v,
  input  logic [a_width-1:0] i_free_tag,
  output logic               o_set_v,
  output logic [a_width-1:0] o_set_a,
  output logic               o_rst_v,
  output logic [a_width-1:0] o_rst_a,
  output logic [a_width:0]   o_free_cnt,
  output logic               o_init_done,
  output logic               o_err
);
  localparam int DEPTH = tag_depth(a_width);
  localparam logic [a_width:0] FULL = {1'b1, {a_width{1'b0}}};
  localparam logic [a_width-1:0] ONE = {{(a_width-1){1'b0}}, 1'b1};
  logic               r_state, w_state_nxt;
  logic [a_width-1:0] r_init_cnt, w_head, w_push_data;
  logic [a_width:0]   w_count;
  logic               w_accept, w_free_ok, w_push;
  logic               r_set_v, r_rst_v, r_err;
  logic [a_width-1:0] r_set_a, r_rst_a;
  assign o_alloc_v   = (r_state == RUN) & (w_count != '0);
  assign o_alloc_tag = w_head;
  assign o_free_cnt  = w_count;
  assign o_init_done = (r_state == RUN);
  assign o_set_v     = r_set_v;
  assign o_set_a     = r_set_a;
  assign o_rst_v     = r_rst_v;
  assign o_rst_a     = r_rst_a;
  assign o_err       = r_err;
  assign w_accept    = o_alloc_v & i_alloc_r;
`ifdef BASE_TAG_FREELIST_CHK_EN
  localparam logic [DEPTH-1:0] BIT0 = {{(DEPTH-1){1'b0}}, 1'b1};
  logic [DEPTH-1:0] r_inuse;
  // The in-use check uses last cycle's vector, so allocating and freeing one tag together is a double free.
  assign w_free_ok = (r_state == RUN) & i_free_v & ((w_count != FULL) | w_accept) & r_inuse[i_free_tag];
  always_ff @(posedge clk) begin
    if (reset) r_inuse <= '0;
    else r_inuse <= (r_inuse | (w_accept ? BIT0 << w_head : '0)) & ~(w_free_ok ? BIT0 << i_free_tag : '0);
  end
`else
  assign w_free_ok = (r_state == RUN) & i_free_v & ((w_count != FULL) | w_accept);
`endif
  assign w_push      = (r_state == INIT) | w_free_ok;
  assign w_push_data = (r_state == INIT) ? r_init_cnt : i_free_tag;
  always_comb w_state_nxt = ((r_state == INIT) && (r_init_cnt == '1)) ? RUN : r_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_set_v    <= 1'b0;
      r_set_a    <= '0;
      r_rst_v    <= 1'b0;
      r_rst_a    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + ONE;
      r_set_v    <= w_accept;
      r_set_a    <= w_head;
      r_rst_v    <= w_free_ok;
      r_rst_a    <= i_free_tag;
      r_err      <= r_err | (i_free_v & ~w_free_ok);
    end
  end
  base_tag_fifo #(.a_width(a_width)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_accept),
    .o_head     (w_head),
    .o_count    (w_count)
  );
endmodule

// File: doc/base_tag_freelist.md
# base_tag_freelist

Free-list tag allocator that sits directly upstream of the per-tag valid-bit array (`base_vmem_bypass`). It hands out unused tags to a requester over a valid/ready handshake and accepts returned tags. It also drives that array's set port on every allocation and one reset port on every free, so the downstream valid bits always mirror the tags in flight.

## Interface
Parameters:
- `a_width`, 4, tag width; `depth = 2**a_width` tags.

Ports:
- `clk` in 1, single clock.
- `reset` in 1, synchronous, active-high.
- `o_alloc_v` out 1, a free tag is offered.
- `i_alloc_r` in 1, requester takes the offered tag.
- `o_alloc_tag` out `a_width`, offered tag.
- `i_free_v` in 1, tag return strobe (no backpressure).
- `i_free_tag` in `a_width`, returned tag.
- `o_set_v` out 1, to valid array `i_set_v`.
- `o_set_a` out `a_width`, to valid array `i_set_a`.
- `o_rst_v` out 1, to valid array `i_rst_v` (one reset port).
- `o_rst_a` out `a_width`, to valid array `i_rst_a`.
- `o_free_cnt` out `a_width+1`, tags currently in the free list.
- `o_init_done` out 1, free list fully populated after reset.
- `o_err` out 1, sticky error (overflow or double free).

## Operation
- **State machine `INIT` -> `RUN`:**
  - `reset` forces `INIT`, init counter = 0, head = tail = 0, count = 0.
  - `INIT` pushes the counter value each cycle, counter 0..depth-1.
  - After pushing depth-1, the block goes to `RUN` and `o_init_done` = 1.
- **Free list:** `depth`-entry register array with head/tail pointers of `a_width` bits. Pointers wrap modulo `depth`.
- **Allocation:**
  - `o_alloc_v = RUN & (count != 0)`.
  - `o_alloc_tag` = entry at head.
  - Accept = `o_alloc_v & i_alloc_r`; it pops the entry.
  - `i_alloc_r` with `o_alloc_v` = 0 is ignored.
- **Free:**
  - `i_free_v` in `RUN` pushes `i_free_tag` at tail.
  - `i_free_v` during `INIT` is dropped and sets `o_err`.
- **Simultaneous accept and free:** both happen and count is unchanged. The freed tag is never bypassed to `o_alloc_tag` in the same cycle; when count = 0 it is offered the next cycle.
- **Overflow:** a free arriving with count = depth and no accept that cycle is dropped and sets `o_err`.
- **Count:** `o_free_cnt` is `a_width+1` bits. Range is 0..depth; it never wraps.
- **Downstream strobes:**
  - Each accept produces `o_set_v`/`o_set_a` = allocated tag.
  - Each accepted free produces `o_rst_v`/`o_rst_a` = freed tag.
  - A tag allocated and freed in the same cycle produces both strobes; the downstream array gives reset priority.
- **`o_err`:** sticky until `reset`.

## Timing
- Reset value of every output is 0, except `o_alloc_tag`, which is 0 because all array entries reset to 0.
- `INIT` lasts exactly `depth` cycles after `reset` deasserts. `o_alloc_v` can first be 1 in cycle `depth`, counting the first non-reset cycle as 0.
- `o_alloc_v`, `o_alloc_tag` and `o_free_cnt` are registered state, not combinational from the same-cycle inputs.
- Set/reset strobes are registered: 1 cycle after the accept/free cycle. Combined with the array's 1-cycle delay, a read of the tag's valid bit is correct 2 cycles after the handshake.
- A free reaches `o_alloc_v` 1 cycle later at the earliest.
- `reset` asserted mid-operation takes effect at the next edge:
  - outstanding tags are forgotten;
  - pending strobes are cleared, with no set/reset emitted;
  - `INIT` restarts.

## Configuration
- **`BASE_TAG_FREELIST_CHK_EN` defined:**
  - A `depth`-bit in-use vector is kept: set on accept, cleared on free.
  - A free of a tag whose bit is 0 is a double free. It is dropped (no push, no `o_rst_v`) and sets `o_err`.
  - Same-cycle accept and free of the same tag is legal only if the tag was already in use.
- **Not defined:**
  - No in-use vector.
  - Only overflow and free-during-`INIT` set `o_err`.
  - Double frees are pushed and duplicate tags become possible.

## Structure
- A shared package/include holds:
  - the `a_width`-derived `depth` computation;
  - the state encoding localparams `INIT` = 1'b0, `RUN` = 1'b1.
- Natural sub-module: `base_tag_fifo`, a register-array FIFO with no bypass exposing head data, count, push and pop. The FSM, init counter, error logic and strobe registers stay in the top level.

## Test plan
- **Reset then init:** deassert `reset`, hold `i_alloc_r` = 1.
  - `o_init_done` rises after `depth` = 16 cycles.
  - Tags 0,1,2,...,15 are allocated in order.
  - `o_free_cnt` counts 16 -> 0.
  - `o_set_v` pulses 1 cycle after each accept with the matching `o_set_a`.
- **Empty plus free:** with all 16 tags allocated, free tag 5.
  - Same cycle: `o_alloc_v` = 0.
  - Next cycle: `o_alloc_v` = 1, `o_alloc_tag` = 5.
  - `o_rst_v`/`o_rst_a` = 5 is emitted 1 cycle after the free.
- **Simultaneous:** count = 3, accept and free tag 9 in the same cycle.
  - Count stays 3.
  - Tag 9 appears after the remaining entries ahead of it.
  - Both strobes fire the next cycle.
- **Overflow:** count = 16, free tag 2 with no accept.
  - Count stays 16, no `o_rst_v`, `o_err` = 1 and it stays 1.
- **Double free (`_EN` defined):** free tag 3 while it is unallocated.
  - Free is dropped, `o_err` = 1.
  - Without the macro, count increments instead and `o_err` stays 0 (when count < 16).
- **Mid-operation reset:** after 7 allocations, pulse `reset`.
  - All outputs are 0 and `INIT` restarts.
  - No set/reset strobes are emitted.
  - Tag 0 is offered again after 16 cycles.
